t05_code_serializer: RTL

Downstream stage of the codebook synthesis stage in the team 05 Huffman compressor. It captures each discovered code (character, path bits, path length) when the codebook walker reports `char_found`, and packs it into a byte stream for the SRAM/output writer using a valid/ready handshake. When the walker signals completion, it emits a two-byte terminator. While a code is being serialized it deasserts `cap_ready`, which the walker uses as its stall input.

---
 rtl/t05_code_serializer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/t05_code_serializer.sv
// Packs each captured Huffman code into a byte stream: char byte, length byte, then path bytes root-side first.
// On codebook completion it appends a 0x00,0x00 terminator and then holds done until reset.
module t05_code_serializer #(
    parameter int PATH_W = 128,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              char_found,
    input  logic [7:0]        char_index,
    input  logic [PATH_W-1:0] char_path,
    input  logic [LEN_W-1:0]  track_length,
    input  logic              cb_finished,
    input  logic              byte_ready,
    output logic              cap_ready,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHAR  = 3'd1;
    localparam logic [2:0] S_LEN   = 3'd2;
    localparam logic [2:0] S_PATH  = 3'd3;
    localparam logic [2:0] S_TERM0 = 3'd4;
    localparam logic [2:0] S_TERM1 = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam int SH_W = $clog2(PATH_W + 1);
    localparam int NB_W = LEN_W - 2;

    logic [2:0]        r_state;
    logic [LEN_W-1:0]  r_len;
    logic [PATH_W-1:0] r_sr;
    logic [NB_W-1:0]   r_nbytes;
    logic              r_fin_pend;
    logic              r_err;
    logic              r_done;
    logic [7:0]        r_byte_out;
    logic              r_byte_valid;

    logic              w_xfer;
    logic              w_busy;
    logic              w_capture;
    logic [SH_W-1:0]   w_shamt;
    logic [LEN_W:0]    w_len_p7;

    assign w_xfer    = r_byte_valid & byte_ready;
    assign w_busy    = (r_state == S_CHAR) | (r_state == S_LEN) | (r_state == S_PATH);
    assign w_capture = (r_state == S_IDLE) & char_found & (track_length != '0);
    // Left-justify the code so the root-side bit lands at the top of the shift register.
    assign w_shamt   = SH_W'(PATH_W) - SH_W'(track_length);
    assign w_len_p7  = {1'b0, track_length} + (LEN_W + 1)'(7);

    assign cap_ready  = (r_state == S_IDLE) & ~r_fin_pend;
    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;
    assign done       = r_done;
    assign err        = r_err;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_sr         <= '0;
            r_nbytes     <= '0;
            r_fin_pend   <= 1'b0;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
            r_byte_out   <= 8'h00;
            r_byte_valid <= 1'b0;
        end else begin
            // Codes offered while busy, or with zero length, are dropped and flagged.
            if (char_found && ((r_state != S_IDLE) || (track_length == '0)))
                r_err <= 1'b1;
            if (cb_finished && (w_busy || w_capture))
                r_fin_pend <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_len        <= track_length;
                        r_sr         <= char_path << w_shamt;
                        r_nbytes     <= w_len_p7[LEN_W:3];
                        r_byte_out   <= char_index;
                        r_byte_valid <= 1'b1;
                        r_state      <= S_CHAR;
                    end else if (cb_finished) begin
                        r_byte_out   <= 8'h00;
                        r_byte_valid <= 1'b1;
                        r_state      <= S_TERM0;
                    end
                end
                S_CHAR: begin
                    if (w_xfer) begin
                        r_byte_out <= 8'(r_len);
                        r_state    <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (w_xfer) begin
                        r_byte_out <= r_sr[PATH_W-1 -: 8];
                        r_sr       <= r_sr << 8;
                        r_nbytes   <= r_nbytes - NB_W'(1);
                        r_state    <= S_PATH;
                    end
                end
                S_PATH: begin
                    if (w_xfer) begin
                        // r_nbytes counts path bytes still to be loaded after the one on the bus.
                        if (r_nbytes == '0) begin
                            if (r_fin_pend || cb_finished) begin
                                r_byte_out <= 8'h00;
                                r_state    <= S_TERM0;
                            end else begin
                                r_byte_valid <= 1'b0;
                                r_state      <= S_IDLE;
                            end
                        end else begin
                            r_byte_out <= r_sr[PATH_W-1 -: 8];
                            r_sr       <= r_sr << 8;
                            r_nbytes   <= r_nbytes - NB_W'(1);
                        end
                    end
                end
                S_TERM0: begin
                    if (w_xfer) begin
                        r_byte_out <= 8'h00;
                        r_state    <= S_TERM1;
                    end
                end
                S_TERM1: begin
                    if (w_xfer) begin
                        r_byte_valid <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_byte_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
